// File: rtl/sys_tile_sequencer.sv
// rtl/sys_tile_sequencer.sv - tile-loop sequencer walking the (i,j,k) tile space of C += A*B
module sys_tile_sequencer #(
  parameter int TILE_M = 4,
  parameter int TILE_N = 4,
  parameter int TILE_K = 4,
  parameter int IDX_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] cfg_m,
  input  logic [IDX_W-1:0] cfg_n,
  input  logic [IDX_W-1:0] cfg_k,
  input  logic             cfg_order,
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [IDX_W-1:0] index_i,
  output logic [IDX_W-1:0] index_j,
  output logic [IDX_W-1:0] index_k,
  output logic             first_k,
  output logic             last_k,
  output logic [CNT_W-1:0] tile_cnt,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [IDX_W-1:0] TM = IDX_W'(TILE_M);
  localparam logic [IDX_W-1:0] TN = IDX_W'(TILE_N);
  localparam logic [IDX_W-1:0] TK = IDX_W'(TILE_K);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] m_q, n_q, k_q;
  logic             order_q;

  logic             cfg_ok;
  logic             at_last_i, at_last_j, at_last_k;
  logic             final_beat, handshake;
  logic [IDX_W-1:0] nxt_i, nxt_j, nxt_k;

  // A dimension is legal only if non-zero and an exact multiple of its tile.
  assign cfg_ok = (cfg_m != '0) && ((cfg_m % TM) == '0) &&
                  (cfg_n != '0) && ((cfg_n % TN) == '0) &&
                  (cfg_k != '0) && ((cfg_k % TK) == '0);

  assign at_last_i  = (index_i == m_q - TM);
  assign at_last_j  = (index_j == n_q - TN);
  assign at_last_k  = (index_k == k_q - TK);
  assign final_beat = at_last_i && at_last_j && at_last_k;
  assign handshake  = tile_valid && tile_ready;

  // Gated by tile_valid so the flags read 0 outside RUN, matching the reset state.
  assign first_k = tile_valid && (index_k == '0);
  assign last_k  = tile_valid && at_last_k;

  always_comb begin
    nxt_i = index_i;
    nxt_j = index_j;
    nxt_k = index_k;
    if (!order_q) begin
      if (!at_last_k) begin
        nxt_k = index_k + TK;
      end else begin
        nxt_k = '0;
        if (!at_last_j) begin
          nxt_j = index_j + TN;
        end else begin
          nxt_j = '0;
          nxt_i = index_i + TM;
        end
      end
    end else begin
      if (!at_last_j) begin
        nxt_j = index_j + TN;
      end else begin
        nxt_j = '0;
        if (!at_last_k) begin
          nxt_k = index_k + TK;
        end else begin
          nxt_k = '0;
          nxt_i = index_i + TM;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      m_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      order_q    <= 1'b0;
      tile_valid <= 1'b0;
      index_i    <= '0;
      index_j    <= '0;
      index_k    <= '0;
      tile_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              m_q        <= cfg_m;
              n_q        <= cfg_n;
              k_q        <= cfg_k;
              order_q    <= cfg_order;
              index_i    <= '0;
              index_j    <= '0;
              index_k    <= '0;
              tile_cnt   <= '0;
              tile_valid <= 1'b1;
              busy       <= 1'b1;
              state      <= S_RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (handshake) begin
            tile_cnt <= tile_cnt + CNT_W'(1);
            if (final_beat) begin
              tile_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              index_i    <= '0;
              index_j    <= '0;
              index_k    <= '0;
              state      <= S_DONE;
            end else begin
              index_i <= nxt_i;
              index_j <= nxt_j;
              index_k <= nxt_k;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
